// File: rtl/cpu_reg_bank_pkg.sv
// Shared constants, access kinds and address-map base helpers for cpu_reg_bank.
package cpu_reg_bank_pkg;

  localparam int ID_IDX      = 0;
  localparam int VERSION_IDX = 1;

  // Returned for reads of unmapped words
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_e;

  function automatic int ro_base();
    return 2;
  endfunction

  function automatic int rw_base(input int num_ro);
    return ro_base() + num_ro;
  endfunction

  function automatic int cnt_base(input int num_ro, input int num_rw);
    return rw_base(num_ro) + num_rw;
  endfunction

endpackage

// File: rtl/cpu_reg_counter.sv
// Clear-on-read event counter; wraps by default, saturates when
// CPU_REG_BANK_SATURATE_EN is defined.
module cpu_reg_counter
  import cpu_reg_bank_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 inc_i,
  input  logic                 clr_on_rd_i,
  output logic [CNT_WIDTH-1:0] value_o
);

  logic [CNT_WIDTH-1:0] value_q;
  logic [CNT_WIDTH-1:0] value_d;

  // Next value: a read clears but keeps a same-cycle event, otherwise count up
  always_comb begin
    value_d = value_q;
    if (clr_on_rd_i) begin
      value_d = CNT_WIDTH'(inc_i);
    end else if (inc_i) begin
`ifdef CPU_REG_BANK_SATURATE_EN
      value_d = (value_q == {CNT_WIDTH{1'b1}}) ? value_q : value_q + CNT_WIDTH'(1);
`else
      value_d = value_q + CNT_WIDTH'(1);
`endif
    end else begin
      value_d = value_q;
    end
  end

  // Counter state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/cpu_reg_bank.sv
// CPU-facing register bank: ID/VERSION, RO inputs, byte-writable RW registers
// and clear-on-read counters (CPU_REG_BANK_SATURATE_EN selects saturating counters).
module cpu_reg_bank
  import cpu_reg_bank_pkg::*;
#(
  parameter int                   ADDR_WIDTH  = 12,
  parameter int                   NUM_RO      = 2,
  parameter int                   NUM_RW      = 2,
  parameter int                   NUM_CNT     = 4,
  parameter int                   CNT_WIDTH   = 32,
  parameter logic [31:0]          ID_VAL      = 32'h0,
  parameter logic [31:0]          VERSION_VAL = 32'h1,
  parameter logic [32*NUM_RW-1:0] RW_DEFAULT  = {NUM_RW{32'h0}}
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         bus_cs_i,
  input  logic                         bus_rnw_i,
  input  logic [ADDR_WIDTH-1:0]        bus_addr_i,
  input  logic [31:0]                  bus_wdata_i,
  input  logic [3:0]                   bus_be_i,
  output logic [31:0]                  bus_rdata_o,
  output logic                         bus_rdack_o,
  output logic                         bus_wrack_o,
  output logic                         bus_error_o,
  input  logic [32*NUM_RO-1:0]         ro_regs_i,
  output logic [32*NUM_RW-1:0]         rw_regs_o,
  output logic [NUM_RW-1:0]            rw_wr_stb_o,
  input  logic [NUM_CNT-1:0]           cnt_inc_i,
  output logic [CNT_WIDTH*NUM_CNT-1:0] cnt_vals_o
);

  localparam int RO_BASE  = ro_base();
  localparam int RW_BASE  = rw_base(NUM_RO);
  localparam int CNT_BASE = cnt_base(NUM_RO, NUM_RW);
  localparam int MAP_END  = CNT_BASE + NUM_CNT;

  logic                         armed_q, armed_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         rdack_q, rdack_d;
  logic                         wrack_q, wrack_d;
  logic                         error_q, error_d;
  logic [32*NUM_RW-1:0]         rw_q, rw_d;
  logic [NUM_RW-1:0]            stb_q, stb_d;

  acc_kind_e                    acc_s;
  int                           wi_s;
  logic                         mapped_s;
  logic [31:0]                  rd_word_s;
  logic [31:0]                  cnt_ext_s;
  logic [NUM_RW-1:0]            rw_hit_s;
  logic [NUM_CNT-1:0]           clr_s;
  logic [CNT_WIDTH*NUM_CNT-1:0] cnt_vals_s;
  logic                         unused_addr_s;

  assign unused_addr_s = ^bus_addr_i[1:0];
  assign wi_s          = int'(bus_addr_i[ADDR_WIDTH-1:2]);
  assign mapped_s      = (wi_s < MAP_END);

  // Classify the current cycle; armed blocks repeat acks while cs stays high
  always_comb begin
    acc_s = ACC_IDLE;
    if (bus_cs_i && armed_q) begin
      acc_s = bus_rnw_i ? ACC_READ : ACC_WRITE;
    end else begin
      acc_s = ACC_IDLE;
    end
  end

  // Word read mux: one-hot OR of every mapped source
  always_comb begin
    rd_word_s = 32'h0;
    cnt_ext_s = 32'h0;
    rd_word_s |= (wi_s == ID_IDX)      ? ID_VAL      : 32'h0;
    rd_word_s |= (wi_s == VERSION_IDX) ? VERSION_VAL : 32'h0;
    for (int i = 0; i < NUM_RO; i++) begin
      rd_word_s |= (wi_s == RO_BASE + i) ? ro_regs_i[32*i +: 32] : 32'h0;
    end
    for (int i = 0; i < NUM_RW; i++) begin
      rd_word_s |= (wi_s == RW_BASE + i) ? rw_q[32*i +: 32] : 32'h0;
    end
    for (int j = 0; j < NUM_CNT; j++) begin
      cnt_ext_s = 32'h0;
      cnt_ext_s[CNT_WIDTH-1:0] = cnt_vals_s[CNT_WIDTH*j +: CNT_WIDTH];
      rd_word_s |= (wi_s == CNT_BASE + j) ? cnt_ext_s : 32'h0;
    end
  end

  // Next-state for handshake, read data, RW registers and counter clears
  always_comb begin
    armed_d = armed_q;
    rw_d    = rw_q;
    case (acc_s)
      ACC_READ:  armed_d = 1'b0;
      ACC_WRITE: armed_d = 1'b0;
      default:   armed_d = bus_cs_i ? armed_q : 1'b1;
    endcase
    for (int i = 0; i < NUM_RW; i++) begin
      rw_hit_s[i] = (acc_s == ACC_WRITE) && (wi_s == RW_BASE + i);
      for (int b = 0; b < 4; b++) begin
        rw_d[32*i+8*b +: 8] = (rw_hit_s[i] && bus_be_i[b]) ?
                              bus_wdata_i[8*b +: 8] : rw_q[32*i+8*b +: 8];
      end
    end
    for (int j = 0; j < NUM_CNT; j++) begin
      clr_s[j] = (acc_s == ACC_READ) && (wi_s == CNT_BASE + j);
    end
    rdack_d = (acc_s == ACC_READ);
    wrack_d = (acc_s == ACC_WRITE);
    rdata_d = rdack_d ? (mapped_s ? rd_word_s : DEADBEEF) : 32'h0;
    error_d = (rdack_d && !mapped_s) || (wrack_d && !(|rw_hit_s));
    stb_d   = rw_hit_s;
  end

  // Bus response and RW register state; reset drops any pending ack
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      armed_q <= 1'b1;
      rdata_q <= 32'h0;
      rdack_q <= 1'b0;
      wrack_q <= 1'b0;
      error_q <= 1'b0;
      rw_q    <= RW_DEFAULT;
      stb_q   <= '0;
    end else begin
      armed_q <= armed_d;
      rdata_q <= rdata_d;
      rdack_q <= rdack_d;
      wrack_q <= wrack_d;
      error_q <= error_d;
      rw_q    <= rw_d;
      stb_q   <= stb_d;
    end
  end

  for (genvar j = 0; j < NUM_CNT; j++) begin : g_cnt
    cpu_reg_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (cnt_inc_i[j]),
      .clr_on_rd_i(clr_s[j]),
      .value_o    (cnt_vals_s[CNT_WIDTH*j +: CNT_WIDTH])
    );
  end

  assign bus_rdata_o = rdata_q;
  assign bus_rdack_o = rdack_q;
  assign bus_wrack_o = wrack_q;
  assign bus_error_o = error_q;
  assign rw_regs_o   = rw_q;
  assign rw_wr_stb_o = stb_q;
  assign cnt_vals_o  = cnt_vals_s;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Directed bench for cpu_reg_bank: a 32-bit-counter instance (A) and a 4-bit-counter instance (B).
module tb_cpu_reg_bank;

  localparam logic [31:0] ID_A  = 32'hC0DE_0001;
  localparam logic [31:0] VER_A = 32'h0001_0002;
  localparam logic [63:0] DEF_A = {32'hA5A5_0000, 32'h1234_5678};

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_a, cs_b, bus_rnw;
  logic [11:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;

  logic [31:0]  rdata_a, rdata_b;
  logic         rdack_a, wrack_a, error_a, rdack_b, wrack_b, error_b;
  logic [63:0]  ro_a = {32'h2222_BBBB, 32'h1111_AAAA};
  logic [31:0]  ro_b = 32'h3333_CCCC;
  logic [63:0]  rw_a;
  logic [31:0]  rw_b;
  logic [1:0]   stb_a;
  logic         stb_b;
  logic [3:0]   cnt_inc_a;
  logic         cnt_inc_b;
  logic [127:0] cnt_vals_a;
  logic [3:0]   cnt_vals_b;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  cpu_reg_bank #(
    .ADDR_WIDTH(12), .NUM_RO(2), .NUM_RW(2), .NUM_CNT(4), .CNT_WIDTH(32),
    .ID_VAL(ID_A), .VERSION_VAL(VER_A), .RW_DEFAULT(DEF_A)
  ) dut_a (
    .clk_i(clk), .reset_i(reset), .bus_cs_i(cs_a), .bus_rnw_i(bus_rnw),
    .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata), .bus_be_i(bus_be),
    .bus_rdata_o(rdata_a), .bus_rdack_o(rdack_a), .bus_wrack_o(wrack_a),
    .bus_error_o(error_a), .ro_regs_i(ro_a), .rw_regs_o(rw_a),
    .rw_wr_stb_o(stb_a), .cnt_inc_i(cnt_inc_a), .cnt_vals_o(cnt_vals_a)
  );

  cpu_reg_bank #(
    .ADDR_WIDTH(12), .NUM_RO(1), .NUM_RW(1), .NUM_CNT(1), .CNT_WIDTH(4)
  ) dut_b (
    .clk_i(clk), .reset_i(reset), .bus_cs_i(cs_b), .bus_rnw_i(bus_rnw),
    .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata), .bus_be_i(bus_be),
    .bus_rdata_o(rdata_b), .bus_rdack_o(rdack_b), .bus_wrack_o(wrack_b),
    .bus_error_o(error_b), .ro_regs_i(ro_b), .rw_regs_o(rw_b),
    .rw_wr_stb_o(stb_b), .cnt_inc_i(cnt_inc_b), .cnt_vals_o(cnt_vals_b)
  );

  // One bus transaction: cs until ack (bounded), then one idle cycle.
  task automatic bus_op(input bit on_b, input bit rnw, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic [3:0] inc_mask,
                        output int lat, output logic [31:0] rd, output logic err,
                        output logic rdk, output logic wrk, output logic [1:0] stb,
                        output logic post);
    @(negedge clk);
    bus_rnw = rnw; bus_addr = addr; bus_wdata = wd; bus_be = be; cnt_inc_a = inc_mask;
    if (on_b) cs_b = 1'b1; else cs_a = 1'b1;
    lat = -1; rd = 32'h0; err = 1'b0; rdk = 1'b0; wrk = 1'b0; stb = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      cnt_inc_a = 4'h0;
      if (on_b ? (rdack_b | wrack_b) : (rdack_a | wrack_a)) begin
        lat = i;
        rd  = on_b ? rdata_b : rdata_a;
        err = on_b ? error_b : error_a;
        rdk = on_b ? rdack_b : rdack_a;
        wrk = on_b ? wrack_b : wrack_a;
        stb = on_b ? {1'b0, stb_b} : stb_a;
        break;
      end
    end
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0;
    @(posedge clk); #1;
    post = rdack_a | wrack_a | rdack_b | wrack_b | (|stb_a) | stb_b;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic err, rdk, wrk, post; logic [1:0] stb;
    reset = 1'b1; cs_a = 1'b0; cs_b = 1'b0; bus_rnw = 1'b0; bus_addr = 12'h0;
    bus_wdata = 32'h0; bus_be = 4'h0; cnt_inc_a = 4'h0; cnt_inc_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (rw_a !== DEF_A) begin fails++; $display("FAIL reset_rw got=%h exp=%h", rw_a, DEF_A); end
    tests_run++; if ({rdata_a, rdack_a, wrack_a, error_a, stb_a} !== 37'h0) begin fails++;
      $display("FAIL reset_bus got rdata=%h rdack=%b wrack=%b err=%b stb=%b exp all 0", rdata_a, rdack_a, wrack_a, error_a, stb_a); end
    tests_run++; if (cnt_vals_a !== 128'h0) begin fails++; $display("FAIL reset_cnt got=%h exp=0", cnt_vals_a); end
    @(negedge clk); reset = 1'b0;
    bus_op(1'b0, 1'b1, 12'h000, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({lat == 1, rdk, wrk} !== 3'b110) begin fails++; $display("FAIL id_ack got lat=%0d rdack=%b wrack=%b exp lat=1 rdack=1", lat, rdk, wrk); end
    tests_run++; if ({rd, err} !== {ID_A, 1'b0}) begin fails++; $display("FAIL id_read got=%h err=%b exp=%h err=0", rd, err, ID_A); end
    bus_op(1'b0, 1'b1, 12'h00C, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({rd, err} !== {32'h2222_BBBB, 1'b0}) begin fails++; $display("FAIL ro1_read got=%h err=%b exp=2222bbbb err=0", rd, err); end
  endtask

  task automatic test_rw_write();
    int lat; logic [31:0] rd; logic err, rdk, wrk, post; logic [1:0] stb;
    bus_op(1'b0, 1'b0, 12'h010, 32'hCAFE_F00D, 4'b0101, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({lat == 1, wrk, rdk, err} !== 4'b1100) begin fails++; $display("FAIL rw_wrack got lat=%0d wrack=%b rdack=%b err=%b exp lat=1 wrack=1", lat, wrk, rdk, err); end
    tests_run++; if (stb !== 2'b01) begin fails++; $display("FAIL rw_stb got=%b exp=01", stb); end
    tests_run++; if (post !== 1'b0) begin fails++; $display("FAIL rw_stb_one_cycle got post=%b exp=0", post); end
    tests_run++; if (rw_a !== {32'hA5A5_0000, 32'h12FE_560D}) begin fails++; $display("FAIL rw_value got=%h exp=a5a5000012fe560d", rw_a); end
    bus_op(1'b0, 1'b1, 12'h013, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({rd, err} !== {32'h12FE_560D, 1'b0}) begin fails++; $display("FAIL rw_readback got=%h err=%b exp=12fe560d err=0", rd, err); end
  endtask

  task automatic test_counter();
    int lat; logic [31:0] rd; logic err, rdk, wrk, post; logic [1:0] stb;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cnt_inc_a = 4'b0100;
    end
    @(negedge clk); cnt_inc_a = 4'h0;
    @(posedge clk); #1;
    tests_run++; if (cnt_vals_a[95:64] !== 32'd5) begin fails++; $display("FAIL cnt2_live got=%0d exp=5", cnt_vals_a[95:64]); end
    bus_op(1'b0, 1'b1, 12'h020, 32'h0, 4'h0, 4'b0100, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({rd, err, lat == 1} !== {32'd5, 1'b0, 1'b1}) begin fails++; $display("FAIL cnt2_read1 got=%0d err=%b lat=%0d exp=5 err=0 lat=1", rd, err, lat); end
    tests_run++; if (cnt_vals_a[95:64] !== 32'd1) begin fails++; $display("FAIL cnt2_after_clear got=%0d exp=1", cnt_vals_a[95:64]); end
    bus_op(1'b0, 1'b1, 12'h020, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if (rd !== 32'd1) begin fails++; $display("FAIL cnt2_read2 got=%0d exp=1", rd); end
    tests_run++; if (cnt_vals_a !== 128'h0) begin fails++; $display("FAIL cnt_all_zero got=%h exp=0", cnt_vals_a); end
  endtask

  task automatic test_cnt_width4();
    int lat; logic [31:0] rd; logic err, rdk, wrk, post; logic [1:0] stb;
    logic [3:0] exp_v;
`ifdef CPU_REG_BANK_SATURATE_EN
    exp_v = 4'd15;
`else
    exp_v = 4'd1;
`endif
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); cnt_inc_b = 1'b1;
    end
    @(negedge clk); cnt_inc_b = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (cnt_vals_b !== exp_v) begin fails++; $display("FAIL w4_live got=%0d exp=%0d", cnt_vals_b, exp_v); end
    bus_op(1'b1, 1'b1, 12'h010, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({rd, err, lat == 1} !== {28'h0, exp_v, 1'b0, 1'b1}) begin fails++; $display("FAIL w4_read1 got=%0d err=%b lat=%0d exp=%0d", rd, err, lat, exp_v); end
    bus_op(1'b1, 1'b1, 12'h010, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if (rd !== 32'd0) begin fails++; $display("FAIL w4_read2 got=%0d exp=0", rd); end
    tests_run++; if (rw_b !== 32'h0) begin fails++; $display("FAIL b_rw_default got=%h exp=0", rw_b); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic err, rdk, wrk, post; logic [1:0] stb;
    bus_op(1'b0, 1'b1, 12'h320, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({rd, err, rdk} !== {32'hDEAD_BEEF, 1'b1, 1'b1}) begin fails++; $display("FAIL unmapped_read got=%h err=%b rdack=%b exp=deadbeef err=1", rd, err, rdk); end
    bus_op(1'b0, 1'b1, 12'h028, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({rd, err} !== {32'hDEAD_BEEF, 1'b1}) begin fails++; $display("FAIL first_unmapped got=%h err=%b exp=deadbeef err=1", rd, err); end
    bus_op(1'b0, 1'b0, 12'h004, 32'hFFFF_FFFF, 4'hF, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({wrk, err, stb} !== 4'b1100) begin fails++; $display("FAIL version_write got wrack=%b err=%b stb=%b exp wrack=1 err=1 stb=00", wrk, err, stb); end
    bus_op(1'b0, 1'b1, 12'h004, 32'h0, 4'h0, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({rd, err} !== {VER_A, 1'b0}) begin fails++; $display("FAIL version_kept got=%h err=%b exp=%h", rd, err, VER_A); end
    bus_op(1'b0, 1'b0, 12'h018, 32'hFFFF_FFFF, 4'hF, 4'h0, lat, rd, err, rdk, wrk, stb, post);
    tests_run++; if ({wrk, err, cnt_vals_a == 128'h0} !== 3'b111) begin fails++; $display("FAIL cnt_write got wrack=%b err=%b cnt=%h exp wrack=1 err=1 cnt=0", wrk, err, cnt_vals_a); end
  endtask

  task automatic test_hold_cs();
    int acks = 0;
    @(negedge clk);
    bus_rnw = 1'b1; bus_addr = 12'h000; cs_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acks += int'(rdack_a | wrack_a);
    end
    @(negedge clk); cs_a = 1'b0;
    @(posedge clk); #1;
    acks += int'(rdack_a | wrack_a);
    tests_run++; if (acks !== 1) begin fails++; $display("FAIL hold_cs_acks got=%0d exp=1", acks); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus_rnw = 1'b0; bus_addr = 12'h014; bus_wdata = 32'hFFFF_FFFF; bus_be = 4'hF;
    cs_a = 1'b1; cnt_inc_a = 4'b1111; reset = 1'b1;
    @(posedge clk); #1;
    tests_run++; if ({rdack_a, wrack_a, error_a, stb_a, rdata_a} !== 37'h0) begin fails++;
      $display("FAIL rst_mid_bus got rdack=%b wrack=%b err=%b stb=%b rdata=%h exp all 0", rdack_a, wrack_a, error_a, stb_a, rdata_a); end
    tests_run++; if ({rw_a, cnt_vals_a} !== {DEF_A, 128'h0}) begin fails++; $display("FAIL rst_mid_state got rw=%h cnt=%h exp rw=%h cnt=0", rw_a, cnt_vals_a, DEF_A); end
    @(negedge clk); reset = 1'b0; cs_a = 1'b0; cnt_inc_a = 4'h0;
    @(posedge clk); #1;
    tests_run++; if ({rdack_a, wrack_a, rw_a} !== {2'b00, DEF_A}) begin fails++; $display("FAIL rst_mid_no_ack got rdack=%b wrack=%b rw=%h", rdack_a, wrack_a, rw_a); end
  endtask

  initial begin
    test_reset();
    test_rw_write();
    test_counter();
    test_cnt_width4();
    test_errors();
    test_hold_cs();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
